// File: rtl/rotate_issue_ctrl.sv
// Issue front end for a 32-bit left-rotate barrel shifter: buffers rotate
// requests, presents the head to the shifter and registers its result.
module rotate_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dir,
  input  logic [4:0]       in_amnt,
  input  logic [31:0]      in_data,
  output logic [4:0]       rot_amnt,
  output logic [31:0]      rot_str,
  input  logic [31:0]      rot_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        dir;
    logic [4:0]  amnt;
    logic [31:0] data;
  } req_t;

  req_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  req_t head;
  logic fifo_nonempty;
  logic push;
  logic load;
  logic out_fire;

  // No pop bypass: a full FIFO refuses input even while it is draining.
  assign in_ready      = (count_q < (AW+1)'(DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign push          = in_valid && in_ready;
  assign load          = fifo_nonempty && (!out_valid_q || out_ready);
  assign out_fire      = out_valid_q && out_ready;
  assign head          = mem_q[rd_ptr_q];

  // A right rotate by n equals a left rotate by (32 - n) mod 32.
  always_comb begin
    rot_amnt = 5'd0;
    rot_str  = 32'd0;
    if (fifo_nonempty) begin
      rot_str  = head.data;
      rot_amnt = head.dir ? (5'd0 - head.amnt) : head.amnt;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    op_count_d  = op_count_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (load) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, load})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_result;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (out_fire) op_count_d = op_count_q + CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      op_count_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      op_count_q  <= op_count_d;
    end
  end

  // NOTE: storage is not reset; entries are only read while count_q marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{dir: in_dir, amnt: in_amnt, data: in_data};
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_rotate_issue_ctrl.sv
// Directed bench for rotate_issue_ctrl with a behavioural left-rotate shifter
// on the return path and an in-order scoreboard on the output handshake.
module tb_rotate_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_dir;
  logic [4:0]  in_amnt;
  logic [31:0] in_data;
  logic [4:0]  rot_amnt;
  logic [31:0] rot_str;
  logic [31:0] rot_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  rotate_issue_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dir     (in_dir),
    .in_amnt    (in_amnt),
    .in_data    (in_data),
    .rot_amnt   (rot_amnt),
    .rot_str    (rot_str),
    .rot_result (rot_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .op_count   (op_count)
  );

  // Stand-in for the combinational left-rotate shifter.
  logic [63:0] dbl;
  assign dbl        = {rot_str, rot_str} << rot_amnt;
  assign rot_result = dbl[63:32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rot(input logic dir, input logic [4:0] a, input logic [31:0] d);
    int n;
    n = int'(a);
    if (n == 0) return d;
    if (dir) return (d >> n) | (d << (32 - n));
    return (d << n) | (d >> (32 - n));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(input logic dir, input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_dir   = dir;
    in_amnt  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Scoreboard: inputs are stable from 1ns after the rising edge, so the
  // falling edge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("order_unexpected", out_data, 32'hxxxxxxxx);
        else check("order", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_rot(in_dir, in_amnt, in_data));
    end
  end

  logic [31:0] burst_exp [5];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_dir    = 1'b0;
    in_amnt   = 5'd0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_op_count", op_count, 0);
    check("rst_rot_amnt", rot_amnt, 0);
    check("rst_rot_str", rot_str, 0);
    #2 rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);

    // Left 1 of 0x80000001
    out_ready = 1'b1;
    drive_one(1'b0, 5'd1, 32'h80000001);
    check("l1_rot_amnt", rot_amnt, 1);
    check("l1_rot_str", rot_str, 32'h80000001);
    check("l1_not_yet_valid", out_valid, 0);
    step();
    check("l1_out_valid", out_valid, 1);
    check("l1_out_data", out_data, 32'h00000003);
    step();
    check("l1_op_count", op_count, 1);
    check("l1_drained", out_valid, 0);

    // Right 4 and right 0
    drive_one(1'b1, 5'd4, 32'h12345678);
    check("r4_rot_amnt", rot_amnt, 28);
    step();
    check("r4_out_data", out_data, 32'h81234567);
    step();
    drive_one(1'b1, 5'd0, 32'hDEADBEEF);
    check("r0_rot_amnt", rot_amnt, 0);
    step();
    check("r0_out_data", out_data, 32'hDEADBEEF);
    step();
    check("r0_op_count", op_count, 3);

    // Back-pressure: five requests with the consumer stalled
    out_ready = 1'b0;
    burst_exp[0] = 32'h000000F0;
    burst_exp[1] = 32'hAB000000;
    burst_exp[2] = 32'h56781234;
    burst_exp[3] = 32'h80000000;
    burst_exp[4] = 32'h00000001;
    in_valid = 1'b1;
    in_dir = 1'b0; in_amnt = 5'd4;  in_data = 32'h0000000F; step();
    in_dir = 1'b1; in_amnt = 5'd8;  in_data = 32'h000000AB; step();
    in_dir = 1'b0; in_amnt = 5'd16; in_data = 32'h12345678; step();
    in_dir = 1'b1; in_amnt = 5'd1;  in_data = 32'h00000001; step();
    in_dir = 1'b0; in_amnt = 5'd31; in_data = 32'h00000002; step();
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_out_data", out_data, burst_exp[0]);
    repeat (3) step();
    check("stall_out_valid", out_valid, 1);
    check("stall_out_data", out_data, burst_exp[0]);
    check("stall_op_count", op_count, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_valid_%0d", i), out_valid, 1);
      check($sformatf("burst_data_%0d", i), out_data, burst_exp[i]);
      step();
    end
    check("burst_empty", out_valid, 0);
    check("burst_op_count", op_count, 8);
    check("burst_in_ready", in_ready, 1);

    // Random stream at full rate
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_dir   = 1'($urandom_range(0, 1));
      in_amnt  = 5'($urandom_range(0, 31));
      in_data  = $urandom;
      step();
      if (i > 0) check($sformatf("stream_valid_%0d", i), out_valid, 1);
    end
    in_valid = 1'b0;
    repeat (2) step();
    check("stream_op_count", op_count, 72);
    check("stream_sb_empty", exp_q.size(), 0);

    // Reset with work in flight
    out_ready = 1'b0;
    drive_one(1'b0, 5'd3, 32'h11111111);
    drive_one(1'b1, 5'd5, 32'h22222222);
    drive_one(1'b0, 5'd7, 32'h33333333);
    check("pre_rst_out_valid", out_valid, 1);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_op_count", op_count, 0);
    check("midrst_rot_str", rot_str, 0);
    step();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_op_count", op_count, 0);

    // Counter wrap
    for (int i = 0; i < 65535; i++) begin
      in_valid = 1'b1;
      in_dir   = 1'($urandom_range(0, 1));
      in_amnt  = 5'($urandom_range(0, 31));
      in_data  = $urandom;
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    check("wrap_max", op_count, 32'h0000FFFF);
    drive_one(1'b0, 5'd9, 32'hCAFEF00D);
    step();
    check("wrap_data", out_data, 32'hFDE01B95);
    step();
    check("wrap_zero", op_count, 0);
    check("wrap_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
